reg_sweep_checker: RTL and testbench
====================================

// Module: reg_sweep_checker
// PURPOSE
//   Synthesisable self-checking register-file sweeper for Pipelined_Processor top-level tests.
//   After start, waits for the program to settle or halt, then drives inr across every register.
//   Samples out_value and compares it against an expected-value image loaded from file.
//   Reports per-register dumps, an error count, the first mismatch and a final pass/fail flag.
//   Sits beside the processor inside a bench wrapper or FPGA self-test top.
// PARAMETERS
//   RegAddrBits   3              width of inr / register index
//   DataWidth     16             register data width
//   TotalReg      8              registers swept (0..TotalReg-1), TotalReg <= 2**RegAddrBits
//   ExpectFile    "expect.txt"   $readmemh image, TotalReg words of DataWidth bits
//   CheckMask     {TotalReg{1'b1}}  bit k=1: compare register k; bit k=0: dump only
//   UseHalt       0              0: wait SettleCycles; 1: wait for halted, bounded by SettleCycles
//   SettleCycles  5              settle delay (UseHalt=0) or halt timeout (UseHalt=1), >=1
//   ReadLatency   1              cycles from inr change to valid out_value, 0..3
// PORTS
//   CLK             in   1            clock, all state on rising edge
//   RST             in   1            asynchronous reset, active-high
//   start           in   1            1-cycle request; honoured only in IDLE or DONE
//   halted          in   1            processor HALT indication (used when UseHalt=1)
//   inr             out  RegAddrBits  register select to processor
//   out_value       in   DataWidth    register value from processor
//   busy            out  1            high in SETTLE/SWEEP
//   done            out  1            high in DONE, held until start or RST
//   pass            out  1            valid with done: err_count==0 && !timeout
//   timeout         out  1            UseHalt=1 and halted not seen within SettleCycles
//   err_count       out  RegAddrBits+1  number of masked mismatches
//   first_err_reg   out  RegAddrBits  index of first mismatch (0 if none)
//   first_err_value out  DataWidth    out_value captured at first mismatch
//   dump_valid      out  1            1-cycle pulse per sampled register
//   dump_reg        out  RegAddrBits  register index of dump
//   dump_value      out  DataWidth    sampled value
// BEHAVIOUR
//   Reset (async, RST=1): state IDLE; every output 0; counters cleared. RST mid-sweep aborts, no done.
//   States: IDLE -> SETTLE -> SWEEP -> DONE; DONE --start--> SETTLE (restart).
//   IDLE/DONE + start: clear err_count, first_err_*, timeout, done, pass; load timer=SettleCycles; go SETTLE.
//   SETTLE, UseHalt=0: count SettleCycles cycles, then SWEEP with inr=0.
//   SETTLE, UseHalt=1: halted=1 -> SWEEP next cycle; timer expiry first -> timeout=1, still SWEEP.
//   SWEEP: per register k: hold inr=k for ReadLatency+1 cycles; sample out_value on last cycle.
//     ReadLatency=0: sample in the same cycle inr=k is driven (one register per cycle).
//   Sample: dump_valid=1, dump_reg=k, dump_value=out_value for one cycle (registered outputs).
//   Mismatch (CheckMask[k] && out_value!=expect[k]): err_count+=1; if err_count was 0, capture first_err_*.
//   err_count saturates at all-ones; no wrap.
//   After sampling k=TotalReg-1: DONE; done=1, pass computed same edge; inr returns to 0.
//   start while busy: ignored. halted outside SETTLE: ignored.
//   Sweep time: SettleCycles (or halt time) + TotalReg*(ReadLatency+1) cycles.
//   expect[] loaded once by $readmemh at elaboration; equality on full DataWidth, unsigned.
// STRUCTURE
//   Header sweep_defs.vh: state encodings ST_IDLE/ST_SETTLE/ST_SWEEP/ST_DONE, 2-bit state width.
//   Sub-module sweep_timer: loadable down-counter (load, value, tick, zero) for settle/timeout/latency.
//   Top: FSM, register index counter, expect ROM, compare/capture, output registers.
// TESTING
//   ADDI program ($2=-22,$3=3,$4=4), matching expect file, UseHalt=0 -> dumps 0,0,FFEA,3,4,0,0,0; done, pass=1, err_count=0.
//   Expect file with reg3=0004 -> err_count=1, first_err_reg=3, first_err_value=0003, pass=0.
//   Same mismatch with CheckMask[3]=0 -> pass=1, dump_value for reg3 still 0003.
//   UseHalt=1, halted never asserted, SettleCycles=20 -> timeout=1 at cycle 20, sweep runs, pass=0.
//   RST pulsed during SWEEP at inr=4 -> all outputs 0 asynchronously, IDLE; new start gives full clean sweep.
//   ReadLatency=2 -> inr held 3 cycles per register, total sweep 24 cycles; start during busy ignored.

Source files
------------

// File: rtl/reg_sweep_checker_pkg.sv
// Shared definitions for the register-file sweep checker.
//   sweep_state_e : FSM state encoding, also driven out on the debug port
//   timer_width   : width of the down-counter that times both the settle /
//                   halt-timeout window and the per-register read latency
package reg_sweep_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SWEEP  = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_e;

    // The timer is loaded with at most max(SettleCycles-1, ReadLatency).
    function automatic int timer_width(input int settle_cycles, input int read_latency);
        int max_load;
        max_load = (settle_cycles > read_latency) ? settle_cycles : read_latency;
        return (max_load < 2) ? 1 : $clog2(max_load + 1);
    endfunction

endpackage

// File: rtl/reg_sweep_checker_timer.sv
// Loadable down-counter used by the sweep checker.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : load value_i (has priority over tick_i)
//   value_i      : load value
//   tick_i       : decrement by one; the count parks at zero
//   zero_o       : count is zero
module reg_sweep_checker_timer #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         tick_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/reg_sweep_checker.sv
// Self-checking register-file sweeper that sits beside a pipelined processor.
// After start it waits for the program to settle (fixed delay) or halt
// (bounded by a timeout), then walks inr over every register, samples
// out_value, dumps each sample and compares it with a constant expect image.
//   CLK, RST              : clock, asynchronous active-high reset
//   start                 : 1-cycle request, honoured in IDLE or DONE only
//   halted                : processor halt flag, used only when UseHalt=1
//   inr / out_value       : register select out, register value back
//   busy / done / pass    : progress and verdict (pass valid with done)
//   timeout               : halt not seen within SettleCycles
//   err_count             : masked mismatches, saturating
//   first_err_reg/_value  : index and sampled value of the first mismatch
//   dump_valid/reg/value  : one pulse per sampled register
//   dbg_state             : current FSM state
// The expected image is a parameter (register k in bits [k*DataWidth +:
// DataWidth]) so the compare ROM is fixed at elaboration.
module reg_sweep_checker
    import reg_sweep_checker_pkg::*;
#(
    parameter int                            RegAddrBits  = 3,
    parameter int                            DataWidth    = 16,
    parameter int                            TotalReg     = 8,
    parameter logic [TotalReg*DataWidth-1:0] ExpectImage  = {16'h0000, 16'h0000, 16'h0000, 16'h0004,
                                                             16'h0003, 16'hFFEA, 16'h0000, 16'h0000},
    parameter logic [TotalReg-1:0]           CheckMask    = '1,
    parameter int                            UseHalt      = 0,
    parameter int                            SettleCycles = 5,
    parameter int                            ReadLatency  = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start,
    input  logic                   halted,
    output logic [RegAddrBits-1:0] inr,
    input  logic [DataWidth-1:0]   out_value,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic [RegAddrBits:0]   err_count,
    output logic [RegAddrBits-1:0] first_err_reg,
    output logic [DataWidth-1:0]   first_err_value,
    output logic                   dump_valid,
    output logic [RegAddrBits-1:0] dump_reg,
    output logic [DataWidth-1:0]   dump_value,
    output sweep_state_e           dbg_state
);

    localparam int                     TimerW     = timer_width(SettleCycles, ReadLatency);
    localparam logic [TimerW-1:0]      SettleLoad = TimerW'(SettleCycles - 1);
    localparam logic [TimerW-1:0]      LatLoad    = TimerW'(ReadLatency);
    localparam logic [RegAddrBits-1:0] LastReg    = RegAddrBits'(TotalReg - 1);

    sweep_state_e           state_q;
    logic [RegAddrBits-1:0] idx_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   pass_q;
    logic                   timeout_q;
    logic [RegAddrBits:0]   err_q;
    logic [RegAddrBits-1:0] first_reg_q;
    logic [DataWidth-1:0]   first_val_q;
    logic                   dump_valid_q;
    logic [RegAddrBits-1:0] dump_reg_q;
    logic [DataWidth-1:0]   dump_value_q;

    logic [DataWidth-1:0] expect_rom [TotalReg];
    for (genvar k = 0; k < TotalReg; k++) begin : g_rom
        assign expect_rom[k] = ExpectImage[k*DataWidth +: DataWidth];
    end

    logic                 take_start;
    logic                 settle_exit;
    logic                 sample_now;
    logic                 last_reg;
    logic                 mismatch;
    logic [RegAddrBits:0] err_d;
    logic                 timer_load;
    logic [TimerW-1:0]    timer_value;
    logic                 timer_tick;
    logic                 timer_zero;

    always_comb begin
        take_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        // With UseHalt the timer only bounds the wait; halted ends it early.
        if (UseHalt != 0) begin
            settle_exit = (state_q == ST_SETTLE) && (halted || timer_zero);
        end else begin
            settle_exit = (state_q == ST_SETTLE) && timer_zero;
        end
        // The timer counts the hold cycles of the current inr; zero marks the
        // last one, where out_value is valid.
        sample_now = (state_q == ST_SWEEP) && timer_zero;
        last_reg   = (idx_q == LastReg);
        mismatch   = sample_now && CheckMask[idx_q] && (out_value != expect_rom[idx_q]);
        err_d      = err_q;
        if (mismatch && (err_q != '1)) begin
            err_d = err_q + 1'b1;
        end
        timer_load  = take_start || settle_exit || (sample_now && !last_reg);
        timer_value = take_start ? SettleLoad : LatLoad;
        timer_tick  = (state_q == ST_SETTLE) || (state_q == ST_SWEEP);
    end

    reg_sweep_checker_timer #(
        .W(TimerW)
    ) u_timer (
        .clk_i  (CLK),
        .rst_i  (RST),
        .load_i (timer_load),
        .value_i(timer_value),
        .tick_i (timer_tick),
        .zero_o (timer_zero)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            err_q        <= '0;
            first_reg_q  <= '0;
            first_val_q  <= '0;
            dump_valid_q <= 1'b0;
            dump_reg_q   <= '0;
            dump_value_q <= '0;
        end else begin
            dump_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (take_start) begin
                        state_q     <= ST_SETTLE;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        timeout_q   <= 1'b0;
                        err_q       <= '0;
                        first_reg_q <= '0;
                        first_val_q <= '0;
                        idx_q       <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_exit) begin
                        state_q <= ST_SWEEP;
                        idx_q   <= '0;
                        if ((UseHalt != 0) && !halted) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                ST_SWEEP: begin
                    if (sample_now) begin
                        dump_valid_q <= 1'b1;
                        dump_reg_q   <= idx_q;
                        dump_value_q <= out_value;
                        err_q        <= err_d;
                        if (mismatch && (err_q == '0)) begin
                            first_reg_q <= idx_q;
                            first_val_q <= out_value;
                        end
                        if (last_reg) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0) && !timeout_q;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign inr             = idx_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign timeout         = timeout_q;
    assign err_count       = err_q;
    assign first_err_reg   = first_reg_q;
    assign first_err_value = first_val_q;
    assign dump_valid      = dump_valid_q;
    assign dump_reg        = dump_reg_q;
    assign dump_value      = dump_value_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_reg_sweep_checker.sv
// Bench for reg_sweep_checker. Three instances cover the configurations:
//   0: fixed settle 5, read latency 1, all registers checked
//   1: halt wait with timeout 20, read latency 2, register 3 dump-only
//   2: halt wait with timeout 6, read latency 0, all registers checked
// Each instance reads a bench-owned register file through a read path with
// the matching latency. Handshake: start is a one-cycle request sampled on
// the rising edge; it is only taken while the checker is idle or done.
module tb_reg_sweep_checker;
    import reg_sweep_checker_pkg::*;

    localparam int NI = 3;
    localparam int NR = 8;
    localparam int SETTLE_T [NI] = '{5, 20, 6};
    localparam int LAT_T    [NI] = '{1, 2, 0};
    localparam int HALT_T   [NI] = '{0, 1, 1};
    localparam int MASK_T   [NI] = '{255, 247, 255};

    logic clk = 1'b0;
    logic rst;

    logic [NI-1:0]       start_s;
    logic [NI-1:0]       halted_s;
    logic [NI-1:0]       busy_s, done_s, pass_s, timeout_s, dv_s;
    logic [NI-1:0][2:0]  inr_s, freg_s, dreg_s;
    logic [NI-1:0][3:0]  err_s;
    logic [NI-1:0][15:0] outv_s, fval_s, dval_s;
    logic [NI-1:0][1:0]  state_s;

    logic [15:0] rf [NI][NR];
    logic [15:0] exp_img [NR];
    logic [15:0] pipe0 = '0;
    logic [15:0] pipe1a = '0;
    logic [15:0] pipe1b = '0;

    logic [18:0] exp_q [$];
    int check_cnt = 0;
    int err_cnt = 0;
    int cur_w = 0;

    always #5 clk = ~clk;

    reg_sweep_checker u_a (
        .CLK(clk), .RST(rst), .start(start_s[0]), .halted(halted_s[0]),
        .inr(inr_s[0]), .out_value(outv_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .pass(pass_s[0]), .timeout(timeout_s[0]), .err_count(err_s[0]),
        .first_err_reg(freg_s[0]), .first_err_value(fval_s[0]), .dump_valid(dv_s[0]),
        .dump_reg(dreg_s[0]), .dump_value(dval_s[0]), .dbg_state(state_s[0])
    );

    reg_sweep_checker #(
        .CheckMask(8'hF7), .UseHalt(1), .SettleCycles(20), .ReadLatency(2)
    ) u_b (
        .CLK(clk), .RST(rst), .start(start_s[1]), .halted(halted_s[1]),
        .inr(inr_s[1]), .out_value(outv_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .pass(pass_s[1]), .timeout(timeout_s[1]), .err_count(err_s[1]),
        .first_err_reg(freg_s[1]), .first_err_value(fval_s[1]), .dump_valid(dv_s[1]),
        .dump_reg(dreg_s[1]), .dump_value(dval_s[1]), .dbg_state(state_s[1])
    );

    reg_sweep_checker #(
        .UseHalt(1), .SettleCycles(6), .ReadLatency(0)
    ) u_c (
        .CLK(clk), .RST(rst), .start(start_s[2]), .halted(halted_s[2]),
        .inr(inr_s[2]), .out_value(outv_s[2]), .busy(busy_s[2]), .done(done_s[2]),
        .pass(pass_s[2]), .timeout(timeout_s[2]), .err_count(err_s[2]),
        .first_err_reg(freg_s[2]), .first_err_value(fval_s[2]), .dump_valid(dv_s[2]),
        .dump_reg(dreg_s[2]), .dump_value(dval_s[2]), .dbg_state(state_s[2])
    );

    // Processor register read paths with 1, 2 and 0 cycles of latency.
    always @(posedge clk) begin
        pipe0  <= rf[0][inr_s[0]];
        pipe1a <= rf[1][inr_s[1]];
        pipe1b <= pipe1a;
    end
    assign outv_s[0] = pipe0;
    assign outv_s[1] = pipe1b;
    assign outv_s[2] = rf[2][inr_s[2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        check_cnt++;
        assert (obs === exp_v) else begin
            err_cnt++;
            $error("FAIL %s (inst %0d): observed %0h expected %0h", tag, cur_w, obs, exp_v);
        end
    endtask

    task automatic load_program(input int w);
        for (int k = 0; k < NR; k++) rf[w][k] = exp_img[k];
    endtask

    task automatic fill_random(input int w);
        for (int k = 0; k < NR; k++) begin
            rf[w][k] = ($urandom_range(0, 2) == 0) ? 16'($urandom) : exp_img[k];
        end
    endtask

    // h = cycle after start at which halted is first sampled high (0: never).
    task automatic run_sweep(input int w, input int h, input bit poke);
        logic [7:0]  m;
        logic [18:0] e;
        int err, fr, fv, st, n, cycles;
        bit to, got;
        cur_w = w;
        m = 8'(MASK_T[w]);
        err = 0; fr = 0; fv = 0;
        exp_q.delete();
        for (int k = 0; k < NR; k++) begin
            exp_q.push_back({3'(k), rf[w][k]});
            if (m[k] && (rf[w][k] != exp_img[k])) begin
                if (err == 0) begin
                    fr = k;
                    fv = int'(rf[w][k]);
                end
                err++;
            end
        end
        if (err > 15) err = 15;
        if ((HALT_T[w] != 0) && (h >= 1) && (h <= SETTLE_T[w])) begin
            to = 1'b0;
            st = h;
        end else begin
            to = (HALT_T[w] != 0);
            st = SETTLE_T[w];
        end
        n = st + NR * (LAT_T[w] + 1);

        @(negedge clk);
        start_s[w] = 1'b1;
        @(posedge clk);
        #1;
        start_s[w] = 1'b0;
        check("busy_after_start", 32'(busy_s[w]), 1);
        got = 1'b0;
        cycles = 0;
        for (int c = 1; c <= 200 && !got; c++) begin
            @(negedge clk);
            if ((h >= 1) && (c == h)) halted_s[w] = 1'b1;
            start_s[w] = poke && (c == 3);
            @(posedge clk);
            #1;
            if (dv_s[w]) begin
                if (exp_q.size() == 0) begin
                    check("dump_extra", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("dump_reg", 32'(dreg_s[w]), 32'(e[18:16]));
                    check("dump_value", 32'(dval_s[w]), 32'(e[15:0]));
                end
            end
            if (done_s[w]) begin
                got = 1'b1;
                cycles = c;
            end
        end
        start_s[w] = 1'b0;
        halted_s[w] = 1'b0;
        check("done_seen", 32'(got), 1);
        check("sweep_cycles", cycles, n);
        check("dumps_left", exp_q.size(), 0);
        check("pass", 32'(pass_s[w]), ((err == 0) && !to) ? 1 : 0);
        check("timeout", 32'(timeout_s[w]), 32'(to));
        check("err_count", 32'(err_s[w]), err);
        check("first_err_reg", 32'(freg_s[w]), fr);
        check("first_err_value", 32'(fval_s[w]), fv);
        check("busy_done", 32'(busy_s[w]), 0);
        check("inr_done", 32'(inr_s[w]), 0);
        check("state_done", 32'(state_s[w]), 32'(ST_DONE));
    endtask

    initial begin
        rst = 1'b1;
        start_s = '0;
        halted_s = '0;
        exp_img = '{16'h0000, 16'h0000, 16'hFFEA, 16'h0003, 16'h0004, 16'h0000, 16'h0000, 16'h0000};
        for (int w = 0; w < NI; w++) load_program(w);

        // Reset state of every instance.
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < NI; w++) begin
            cur_w = w;
            check("rst_busy", 32'(busy_s[w]), 0);
            check("rst_done", 32'(done_s[w]), 0);
            check("rst_pass", 32'(pass_s[w]), 0);
            check("rst_timeout", 32'(timeout_s[w]), 0);
            check("rst_err", 32'(err_s[w]), 0);
            check("rst_inr", 32'(inr_s[w]), 0);
            check("rst_dump_valid", 32'(dv_s[w]), 0);
            check("rst_state", 32'(state_s[w]), 32'(ST_IDLE));
        end
        @(negedge clk);
        rst = 1'b0;

        // Instance 0: ADDI program matches, then reg3 corrupted (start poked while busy).
        run_sweep(0, 0, 1'b0);
        rf[0][3] = 16'h0004;
        run_sweep(0, 0, 1'b1);
        repeat (3) begin
            fill_random(0);
            run_sweep(0, $urandom_range(1, 8), 1'b0);
        end

        // Instance 1: reg3 dump-only; no halt gives timeout, then halt at cycle 7.
        load_program(1);
        rf[1][3] = 16'h0004;
        run_sweep(1, 0, 1'b1);
        run_sweep(1, 7, 1'b0);
        repeat (2) begin
            fill_random(1);
            run_sweep(1, $urandom_range(0, 25), 1'b0);
        end

        // Instance 2: zero read latency, halt-driven settle.
        load_program(2);
        run_sweep(2, 2, 1'b1);
        repeat (3) begin
            fill_random(2);
            run_sweep(2, $urandom_range(0, 8), 1'b0);
        end

        // Asynchronous reset while instance 0 is sweeping register 4.
        cur_w = 0;
        load_program(0);
        @(negedge clk);
        start_s[0] = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 60 && !seen; c++) begin
                @(posedge clk);
                #1;
                if (inr_s[0] == 3'd4) seen = 1'b1;
            end
            check("reached_inr4", 32'(seen), 1);
        end
        #2;
        rst = 1'b1;
        #1;
        check("arst_inr", 32'(inr_s[0]), 0);
        check("arst_busy", 32'(busy_s[0]), 0);
        check("arst_state", 32'(state_s[0]), 32'(ST_IDLE));
        cur_w = 1;
        check("arst_other_done", 32'(done_s[1]), 0);
        cur_w = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("no_done_after_abort", 32'(done_s[0]), 0);
        check("idle_after_abort", 32'(state_s[0]), 32'(ST_IDLE));
        run_sweep(0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
